// File: rtl/ram_controller.sv
// Initiator for the on-chip RAM strobe interface: turns single-word valid/ready
// requests into WR or RD1/RD2 strobe sequences and returns read data as a one-cycle pulse.
module ram_controller #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n
);

    typedef enum logic [1:0] {IDLE, WR, RD1, RD2} state_t;

    state_t            state_q, state_d;
    logic              drive_en, drive_en_d;
    logic              ce_n_d, oe_n_d, we_n_d;
    logic              ready_d, rsp_valid_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_d;
    logic              accept;

    assign accept   = req_valid && req_ready;
    assign ram_data = drive_en ? wdata_q : 'z;

    // State and every output flop; strobes are decoded from the next state so they are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ram_ce_n  <= 1'b1;
            ram_oe_n  <= 1'b1;
            ram_we_n  <= 1'b1;
            drive_en  <= 1'b0;
            ram_addr  <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            req_ready <= 1'b1;
        end else begin
            state_q   <= state_d;
            ram_ce_n  <= ce_n_d;
            ram_oe_n  <= oe_n_d;
            ram_we_n  <= we_n_d;
            drive_en  <= drive_en_d;
            ram_addr  <= addr_d;
            wdata_q   <= wdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rdata_d;
            req_ready <= ready_d;
        end
    end

    // Next state, request latching and read capture.
    always_comb begin
        state_d     = state_q;
        addr_d      = ram_addr;
        wdata_d     = wdata_q;
        rdata_d     = rsp_rdata;
        rsp_valid_d = 1'b0;
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        drive_en_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = req_we ? WR : RD1;
                end
            end
            WR:  state_d = IDLE;
            RD1: state_d = RD2;
            RD2: begin
                state_d     = IDLE;
                rdata_d     = ram_data;
                rsp_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Writes pass through IDLE before any read, so drive_en and oe_n never overlap.
        case (state_d)
            WR: begin
                ce_n_d     = 1'b0;
                we_n_d     = 1'b0;
                drive_en_d = 1'b1;
            end
            RD1, RD2: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
            end
            default: ;
        endcase

        ready_d = (state_d == IDLE);
    end

endmodule

// File: tb/tb_ram_controller.sv
// Bench for ram_controller: behavioural RAM with registered read output, table-driven
// transactions plus hand sequences for held-valid sweep and mid-operation reset.
module tb_ram_controller;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] ram_addr;
    wire  [DATA_W-1:0] ram_data;
    logic              ram_ce_n, ram_oe_n, ram_we_n;

    int n_checks = 0;
    int n_pass   = 0;
    logic chk_en = 1'b0;

    ram_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
    );

    always #5 clk = ~clk;

    // RAM model: writes at the edge ending a write cycle, registers output at the
    // edge ending the first read cycle and drives the bus from then while oe_n is low.
    logic [DATA_W-1:0] mem [64];
    logic [DATA_W-1:0] ram_dout = '0;
    logic              ram_drive = 1'b0;

    initial for (int i = 0; i < 64; i++) mem[i] = '0;

    always @(posedge clk) begin
        if (!ram_ce_n && !ram_we_n) mem[ram_addr] <= ram_data;
        ram_drive <= !ram_ce_n && !ram_oe_n && ram_we_n;
        if (!ram_ce_n && !ram_oe_n && ram_we_n) ram_dout <= mem[ram_addr];
    end

    assign ram_data = (ram_drive && !ram_oe_n && !ram_ce_n) ? ram_dout : 'z;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Bus-safety monitor on the falling edge, away from updates.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("no_drive_with_oe", 32'(dut.drive_en && !ram_oe_n), 32'd0);
            if (!ram_we_n) chk("wdata_known", 32'($isunknown(ram_data)), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_strobes"}, 32'({ram_ce_n, ram_oe_n, ram_we_n}), 32'h7);
        chk({tag, "_bus_released"}, 32'(dut.drive_en), 32'd0);
    endtask

    // One transaction, called one sample after an edge with the DUT idle.
    // Leaves req_valid = hold after acceptance; returns at the first idle sample afterwards.
    task automatic do_req(input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] exp,
                          input logic hold);
        chk("pre_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        step();
        req_valid = hold;
        chk("busy_ready0", 32'(req_ready), 32'd0);
        chk("prev_rsp_one_cycle", 32'(rsp_valid), 32'd0);
        chk("ram_addr", 32'(ram_addr), 32'(a));
        if (we) begin
            chk("wr_strobes", 32'({ram_ce_n, ram_oe_n, ram_we_n}), 32'h2);
            chk("wr_bus", 32'(ram_data), 32'(wd));
            step();
            chk_idle("after_wr");
            chk("ram_written", 32'(mem[a]), 32'(wd));
        end else begin
            chk("rd1_strobes", 32'({ram_ce_n, ram_oe_n, ram_we_n}), 32'h1);
            step();
            chk("rd2_strobes", 32'({ram_ce_n, ram_oe_n, ram_we_n}), 32'h1);
            chk("rd2_ready0", 32'(req_ready), 32'd0);
            chk("rd2_no_rsp", 32'(rsp_valid), 32'd0);
            step();
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_rdata", 32'(rsp_rdata), 32'(exp));
            chk_idle("after_rd");
        end
    endtask

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b0, 6'h3F, 5'h00, 5'h00};   // unwritten location reads zero
        vecs[1] = '{1'b1, 6'h2A, 5'h15, 5'h00};
        vecs[2] = '{1'b0, 6'h2A, 5'h00, 5'h15};
        vecs[3] = '{1'b1, 6'h00, 5'h1F, 5'h00};
        vecs[4] = '{1'b1, 6'h3F, 5'h0A, 5'h00};
        vecs[5] = '{1'b0, 6'h00, 5'h00, 5'h1F};
        vecs[6] = '{1'b0, 6'h3F, 5'h00, 5'h0A};
        vecs[7] = '{1'b1, 6'h2A, 5'h03, 5'h00};
        vecs[8] = '{1'b0, 6'h2A, 5'h00, 5'h03};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        step(); step();
        chk_idle("reset");
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("reset_ram_addr", 32'(ram_addr), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        step();
        chk_idle("post_reset");

        for (int i = 0; i < 9; i++)
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, 1'b0);

        // Back-to-back with req_valid never dropping: write every word, then read it back.
        for (int a = 0; a < 64; a++)
            do_req(1'b1, 6'(a), 5'(a), 5'h00, 1'b1);
        for (int a = 0; a < 64; a++)
            do_req(1'b0, 6'(a), 5'h00, 5'(a), (a != 63));
        step();
        chk("sweep_rsp_pulse_end", 32'(rsp_valid), 32'd0);

        // Reset during RD2 of a read to 0x10: response dropped, bus idle.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 6'h10;
        step();
        req_valid = 1'b0;
        chk("rst_rd1_strobes", 32'({ram_ce_n, ram_oe_n, ram_we_n}), 32'h1);
        step();
        chk("rst_rd2_strobes", 32'({ram_ce_n, ram_oe_n, ram_we_n}), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_rd2_no_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_rd2_rdata_cleared", 32'(rsp_rdata), 32'd0);
        chk_idle("rst_rd2");
        do_req(1'b0, 6'h10, 5'h00, 5'h10, 1'b0);

        // Reset during WR: the write still lands because strobes were already asserted.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 6'h05; req_wdata = 5'h1A;
        step();
        req_valid = 1'b0;
        chk("rst_wr_strobes", 32'({ram_ce_n, ram_oe_n, ram_we_n}), 32'h2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("rst_wr");
        chk("rst_wr_mem", 32'(mem[5]), 32'h1A);
        do_req(1'b0, 6'h05, 5'h00, 5'h1A, 1'b0);

        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
